// File: rtl/instr_fetch.sv
// Instruction fetch unit: single-outstanding memory requests feeding a small
// circular instruction buffer, with redirect flush and in-flight response drain.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned    AW   = $clog2(DEPTH);
  localparam int unsigned    CW   = AW + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     target_q, target_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic [31:0]     buf_data_q [DEPTH];
  logic [31:0]     buf_pc_q   [DEPTH];
  logic [31:0]     redir_pc;
  logic            push, pop;

  assign redir_pc = redirect_pc & ~32'h3;

  // pc_q doubles as the outstanding request address; it only moves on an ack
  // or when no request is in flight, which keeps imem_addr stable.
  assign imem_req    = !reset && (state_q != STALL);
  assign imem_addr   = reset ? RESET_PC : pc_q;
  assign instr_valid = !reset && (count_q != '0);
  assign instruction = instr_valid ? buf_data_q[head_q] : '0;
  assign instr_pc    = instr_valid ? buf_pc_q[head_q]   : '0;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    push     = 1'b0;
    pop      = 1'b0;
    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      unique case (state_q)
        FETCH: begin
          if (imem_ack) begin
            pc_d = redir_pc;
          end else begin
            target_d = redir_pc;
            state_d  = DRAIN;
          end
        end
        STALL: begin
          pc_d    = redir_pc;
          state_d = FETCH;
        end
        DRAIN: begin
          target_d = redir_pc;
          if (imem_ack) begin
            pc_d    = redir_pc;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end else begin
      pop  = instr_valid && instr_ready;
      push = (state_q == FETCH) && imem_ack;
      if (push) begin
        tail_d = tail_q + AW'(1);
        pc_d   = pc_q + 32'd4;
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      unique case (state_q)
        FETCH, STALL: state_d = (count_d == FULL) ? STALL : FETCH;
        DRAIN: begin
          if (imem_ack) begin
            pc_d    = target_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
      count_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      count_q  <= count_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      buf_data_q[tail_q] <= imem_data;
      buf_pc_q[tail_q]   <= pc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed scenarios push expected words,
// a negedge monitor checks every decoder handshake and request stability.
module tb_instr_fetch;

  localparam int unsigned LAT = 3;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_ready;

  logic        zero_wait, lat_en, lat_ack, ack_force;
  int unsigned wcnt;
  int          tests, fails;
  logic [31:0] exp_q [$];

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_data = mem_word(imem_addr);
  assign imem_ack  = ack_force | (zero_wait & imem_req) | lat_ack;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // Fixed-latency responder: ack LAT cycles after the request first appears.
  always @(posedge clock) begin
    #3;
    if (lat_en && imem_req) begin
      if (wcnt == LAT) begin
        lat_ack = 1'b1;
        wcnt    = 0;
      end else begin
        lat_ack = 1'b0;
        wcnt++;
      end
    end else begin
      lat_ack = 1'b0;
      wcnt    = 0;
    end
  end

  logic        prev_req, prev_ack;
  logic [31:0] prev_addr;
  initial begin
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
  end

  always @(negedge clock) begin
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_instr_pc", instr_pc, 32'hDEAD_BEEF ^ instr_pc ^ 32'h1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", instr_pc, e);
        chk("sb_instr", instruction, mem_word(e));
      end
    end
    if (!instr_valid) begin
      chk("idle_zero", instruction | instr_pc, 32'h0);
    end
    if (!reset && prev_req && !prev_ack) begin
      chk("req_held", {31'b0, imem_req}, 32'h1);
      chk("addr_held", imem_addr, prev_addr);
    end
    prev_req  = imem_req;
    prev_ack  = imem_ack;
    prev_addr = imem_addr;
  end

  task automatic do_reset(input int n);
    tick();
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("rst_req", {31'b0, imem_req}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", {31'b0, instr_valid}, 32'h0);
      chk("rst_instr", instruction, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      if (i < n - 1) tick();
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    @(negedge clock);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    zero_wait = 1'b0; lat_en = 1'b0; lat_ack = 1'b0; ack_force = 1'b0; wcnt = 0;

    // Zero-wait streaming from RESET_PC, one instruction per cycle.
    zero_wait = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    do_reset(3);
    @(negedge clock);
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 7) zero_wait = 1'b0;
      @(negedge clock);
      chk("stream_valid", {31'b0, instr_valid}, 32'h1);
      chk("stream_pc", instr_pc, 32'(i * 4));
    end
    wait_empty("stream_drained");

    // Buffer fills and stalls, one pop restarts fetch at the next address.
    instr_ready = 1'b0; zero_wait = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    do_reset(2);
    tick();
    @(negedge clock);
    chk("fill_pc", instr_pc, 32'h0);
    chk("fill_addr", imem_addr, 32'h4);
    tick();
    @(negedge clock);
    chk("stall_req", {31'b0, imem_req}, 32'h0);
    tick();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    @(negedge clock);
    chk("unstall_req", {31'b0, imem_req}, 32'h1);
    chk("unstall_addr", imem_addr, 32'h8);
    tick();
    instr_ready = 1'b1; zero_wait = 1'b0;
    @(negedge clock);
    chk("restall_req", {31'b0, imem_req}, 32'h0);
    wait_empty("stall_drained");

    // Redirect to the top of the address space, pc wraps to zero.
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; zero_wait = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    tick();
    redirect = 1'b0;
    @(negedge clock);
    chk("wrap_flush", {31'b0, instr_valid}, 32'h0);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    @(negedge clock);
    chk("wrap_addr1", imem_addr, 32'h0);
    tick();
    zero_wait = 1'b0;
    wait_empty("wrap_drained");

    // Redirects during an outstanding slow request: old address held, data dropped.
    zero_wait = 1'b0; lat_en = 1'b1; instr_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h100);
    do_reset(2);
    repeat (4) tick();
    @(negedge clock);
    chk("lat_first_pc", instr_pc, 32'h0);
    chk("lat_addr4", imem_addr, 32'h4);
    tick();
    redirect = 1'b1; redirect_pc = 32'h500;
    tick();
    redirect_pc = 32'h103;
    @(negedge clock);
    chk("drain_addr_a", imem_addr, 32'h4);
    tick();
    redirect = 1'b0;
    @(negedge clock);
    chk("drain_addr_b", imem_addr, 32'h4);
    chk("drain_req", {31'b0, imem_req}, 32'h1);
    tick();
    @(negedge clock);
    chk("drain_new_addr", imem_addr, 32'h100);
    chk("drain_valid", {31'b0, instr_valid}, 32'h0);
    repeat (4) tick();
    @(negedge clock);
    chk("drain_first_pc", instr_pc, 32'h100);
    lat_en = 1'b0;
    wait_empty("drain_drained");

    // Redirect coincident with ack and pop.
    zero_wait = 1'b1; instr_ready = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h200);
    do_reset(2);
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clock);
    chk("coinc_head", instr_pc, 32'h4);
    tick();
    redirect = 1'b0;
    @(negedge clock);
    chk("coinc_flush", {31'b0, instr_valid}, 32'h0);
    chk("coinc_addr", imem_addr, 32'h200);
    tick();
    zero_wait = 1'b0;
    @(negedge clock);
    chk("coinc_pc", instr_pc, 32'h200);
    wait_empty("coinc_drained");

    // Redirect while stalled.
    instr_ready = 1'b0; zero_wait = 1'b1;
    do_reset(2);
    tick();
    tick();
    @(negedge clock);
    chk("stl_req", {31'b0, imem_req}, 32'h0);
    tick();
    redirect = 1'b1; redirect_pc = 32'h40; zero_wait = 1'b0;
    tick();
    redirect = 1'b0;
    @(negedge clock);
    chk("stl_redir_valid", {31'b0, instr_valid}, 32'h0);
    chk("stl_redir_req", {31'b0, imem_req}, 32'h1);
    chk("stl_redir_addr", imem_addr, 32'h40);

    // Reset over an outstanding request with ack and redirect in the reset cycle.
    tick();
    zero_wait = 1'b1;
    tick();
    zero_wait = 1'b0;
    @(negedge clock);
    chk("pre_rst_pc", instr_pc, 32'h40);
    chk("pre_rst_addr", imem_addr, 32'h44);
    tick();
    reset = 1'b1; ack_force = 1'b1; redirect = 1'b1; redirect_pc = 32'h300; instr_ready = 1'b1;
    @(negedge clock);
    chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
    chk("mid_rst_valid", {31'b0, instr_valid}, 32'h0);
    tick();
    reset = 1'b0; ack_force = 1'b0; redirect = 1'b0;
    @(negedge clock);
    chk("post_rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("post_rst_req", {31'b0, imem_req}, 32'h1);
    chk("post_rst_addr", imem_addr, 32'h0);
    tick();
    @(negedge clock);
    chk("final_queue", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, first fetch address after reset (word-aligned).
REQ-002 Parameter DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-003 clock  input  1  single clock, all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  byte address of requested word.
REQ-007 imem_ack  input  1  one-cycle pulse: imem_data valid this cycle.
REQ-008 imem_data  input  32  fetched instruction word.
REQ-009 redirect  input  1  branch/jump taken: flush and refetch.
REQ-010 redirect_pc  input  32  new fetch address.
REQ-011 instr_valid  output  1  buffer head valid toward decoder.
REQ-012 instruction  output  32  buffer head instruction word, fed unchanged to the I/R/J decoders.
REQ-013 instr_pc  output  32  address of the head instruction.
REQ-014 instr_ready  input  1  decoder accepts head this cycle.

Function
REQ-015 At most one memory request outstanding; imem_req and imem_addr held stable from assertion until the cycle imem_ack is high.
REQ-016 imem_ack may be high in the same cycle imem_req first rises (zero-wait memory); imem_ack while imem_req low is ignored.
REQ-017 FSM states: FETCH (imem_req=1), STALL (imem_req=0, buffer full), DRAIN (imem_req=1, response to be discarded).
REQ-018 FETCH: on imem_ack, push {imem_data, imem_addr} into buffer, fetch pc += 4; stay FETCH if post-push count < DEPTH, else go STALL.
REQ-019 STALL -> FETCH in the cycle after count drops below DEPTH.
REQ-020 Pop when instr_valid && instr_ready; push and pop in the same cycle leave count unchanged.
REQ-021 Push-to-output latency: word acked in cycle N appears on instruction/instr_valid in cycle N+1.
REQ-022 Sustained throughput 1 instruction/cycle with zero-wait memory and instr_ready held high.
REQ-023 instr_valid = (count != 0); when count == 0, instruction and instr_pc drive 0.
REQ-024 Fetch pc arithmetic modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000.
REQ-025 redirect: buffer flushed (count=0), fetch pc <= redirect_pc with low two bits forced to 0, instr_valid low next cycle.
REQ-026 redirect while request outstanding and imem_ack low: go DRAIN; keep old imem_addr until ack, discard that data, then FETCH at new pc.
REQ-027 redirect in the same cycle as imem_ack: acked data discarded, next cycle FETCH at new pc.
REQ-028 redirect while in DRAIN: latest redirect_pc replaces stored target; remain DRAIN.
REQ-029 redirect has priority over pop and push; a pop in the redirect cycle has no further effect.
REQ-030 redirect in STALL: flush, go FETCH at new pc next cycle.

Reset
REQ-031 While reset high: state FETCH-pending, imem_req=0, imem_addr=RESET_PC, fetch pc=RESET_PC, count=0, instr_valid=0, instruction=0, instr_pc=0.
REQ-032 First cycle after reset deasserts: imem_req=1, imem_addr=RESET_PC.
REQ-033 Reset mid-operation abandons any outstanding request; its later ack is ignored (imem_req low).
REQ-034 Reset overrides redirect, imem_ack and instr_ready.

Verification
REQ-035 Zero-wait memory, instr_ready=1, RESET_PC=0 -> instr_pc 0,4,8,... on consecutive cycles starting 2 cycles after reset release.
REQ-036 instr_ready=0, DEPTH=2 -> after 2 acks imem_req=0 (STALL); one pop -> imem_req=1 next cycle, imem_addr=8.
REQ-037 Memory acks 3 cycles after request; redirect=1, redirect_pc=32'h103 in the second wait cycle -> imem_addr stays old until ack, data discarded, then imem_addr=32'h100, first valid instr_pc=32'h100.
REQ-038 redirect coincident with imem_ack and pop -> acked word never appears, instr_valid=0 next cycle, next imem_addr=redirect target.
REQ-039 redirect_pc=32'hFFFFFFFC, zero-wait -> instr_pc FFFFFFFC then 00000000.
REQ-040 reset pulsed during outstanding request, ack arrives in reset cycle -> no push, instr_valid=0, post-reset imem_addr=RESET_PC.
